eth_zbt_write_buffer: RTL
=========================

Name: eth_zbt_write_buffer

Overview:
- Sits directly downstream of the Ethernet-to-ZBT receive interface, in the same `clock` domain.
- Consumes its single-cycle write pulses (24-bit word address, 32-bit data) and its ETH_active flag.
- Buffers the writes in a small show-ahead FIFO and drains them to the ZBT SRAM controller write port over a req/ack handshake.
- Returns ZBT_ready_O, which gates pause-frame requests upstream; also reports load completion, word count and overflow/range errors.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- ZBT_AW, 19, ZBT word-address width; input addresses with bits [23:ZBT_AW] nonzero are out of range.

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- Write_en_I  input  1  one-cycle write strobe from the Ethernet interface.
- Address_I  input  24  word address, valid with Write_en_I.
- Data_I  input  32  write data, valid with Write_en_I.
- ETH_active_I  input  1  high while an upstream packet stream is being loaded.
- ZBT_ack_I  input  1  ZBT controller accepts the presented write this cycle.
- ZBT_req_O  output  1  write request to the ZBT controller.
- ZBT_address_O  output  ZBT_AW  write address.
- ZBT_data_O  output  32  write data.
- ZBT_ready_O  output  1  buffer idle; upstream may issue a pause request.
- Load_done_O  output  1  one-cycle pulse: load finished and fully committed to ZBT.
- Words_written_O  output  24  count of completed ZBT writes in the current load.
- Overflow_O  output  1  sticky: a write was dropped because the FIFO was full.
- Range_error_O  output  1  sticky: a write was dropped because its address was out of range.

Behaviour:
- Reset: asynchronous, active-low, on resetn only.
  - All outputs 0, except ZBT_ready_O = 1 once the FSM reaches IDLE (the first clock after reset release).
  - FIFO pointers cleared; contents discarded. Reset mid-handshake drops the in-flight request without waiting for ack.
- Accept (sampled at edge E0 with Write_en_I = 1):
  - Address out of range: drop the write, set Range_error_O.
  - Else, FIFO full and no pop at the same edge: drop the write, set Overflow_O.
  - Else: push {Address_I[ZBT_AW-1:0], Data_I}. A push and a pop at the same edge when full is accepted; occupancy is unchanged.
- Outputs are registered. For an empty FIFO in IDLE, ZBT_req_O rises at edge E1, with address and data loaded from the FIFO head.
- Handshake:
  - ZBT_req_O, ZBT_address_O and ZBT_data_O are held stable until an edge where ZBT_req_O and ZBT_ack_I are both 1.
  - That edge completes the transfer: pop the FIFO and increment Words_written_O.
  - If another entry is available after the pop, it is presented at the same edge and ZBT_req_O stays high, giving back-to-back throughput of 1 write/cycle under continuous ack.
  - ZBT_ack_I while ZBT_req_O = 0 is ignored.
- FSM:
  - IDLE: ZBT_req_O = 0. Go to WRITE if the FIFO is non-empty. Otherwise, if done_pending, go to DONE.
  - WRITE: ZBT_req_O = 1. On ack, go to IDLE if the FIFO becomes empty and no push is landing at that edge; otherwise stay in WRITE.
  - DONE: Load_done_O = 1 for exactly one cycle; clear done_pending; go to IDLE.
- done_pending:
  - Set on a falling edge of ETH_active_I (registered prev-value detect).
  - Cleared on a rising edge of ETH_active_I or in DONE.
  - When a rise and a fall are both seen before a drain completes, the most recent edge wins.
- Rising edge of ETH_active_I: clears Words_written_O, Overflow_O and Range_error_O one cycle after the edge is seen.
  - A completion at the same edge counts as 1, not 0.
  - The increment takes priority after the clear.
- Words_written_O wraps modulo 2^24.
- ZBT_ready_O = (state == IDLE) & FIFO empty & ~ETH_active_I & ~done_pending. It is registered, so there is 1 cycle of lag.
- Writes arriving while ETH_active_I = 0 are still accepted and drained; they delay ZBT_ready_O accordingly.

Test Plan:
- Single write: Address_I=0x000123, Data_I=0xDEADBEEF, ack tied 1 -> ZBT_req_O high exactly 1 cycle at E1, ZBT_address_O=0x00123, data 0xDEADBEEF; Words_written_O=1.
- Back-pressure: 3 writes on consecutive cycles, ack held 0 for 10 cycles, then 1 -> outputs stable during the stall; writes emerge in order on 3 consecutive cycles; Words_written_O=3.
- Overflow: ack=0, 17 writes with FIFO_DEPTH=16 -> 17th dropped, Overflow_O=1; after ack=1, exactly 16 writes emerge; Overflow_O stays 1 until the next ETH_active_I rise.
- Full with simultaneous pop: FIFO full, ack=1 and Write_en_I=1 at the same edge -> write accepted, no overflow, occupancy stays 16.
- Range error: Address_I=0x080000 (ZBT_AW=19) -> no ZBT_req_O, Range_error_O=1, Words_written_O unchanged.
- Load done: ETH_active_I rise, 5 writes, ETH_active_I falls while 2 are still buffered -> Load_done_O pulses once, 1 cycle after the last ack; ZBT_ready_O=1 the cycle after that. Reset asserted mid-WRITE -> ZBT_req_O=0 immediately, and no Load_done_O pulse after reset release.

Source files
------------

// File: rtl/eth_zbt_write_buffer.sv
// Show-ahead write buffer between the Ethernet receive interface and the ZBT SRAM
// controller write port, with load-completion, word-count and drop reporting.
module eth_zbt_write_buffer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ZBT_AW     = 19
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              Write_en_I,
  input  logic [23:0]       Address_I,
  input  logic [31:0]       Data_I,
  input  logic              ETH_active_I,
  input  logic              ZBT_ack_I,
  output logic              ZBT_req_O,
  output logic [ZBT_AW-1:0] ZBT_address_O,
  output logic [31:0]       ZBT_data_O,
  output logic              ZBT_ready_O,
  output logic              Load_done_O,
  output logic [23:0]       Words_written_O,
  output logic              Overflow_O,
  output logic              Range_error_O
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ZBT_AW + 32;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count, count_next;
  logic          eth_prev, done_pending, done_pending_next;
  logic          eth_rise, eth_fall;
  logic          range_bad, full, pop, push, drop_full, drop_range;
  logic          next_idle, ready_next;
  logic [EW-1:0] push_entry, next_head;

  assign range_bad  = |(Address_I >> ZBT_AW);
  assign full       = (count == (PW+1)'(FIFO_DEPTH));
  assign pop        = ZBT_req_O & ZBT_ack_I;
  assign push       = Write_en_I & ~range_bad & (~full | pop);
  assign drop_full  = Write_en_I & ~range_bad & full & ~pop;
  assign drop_range = Write_en_I & range_bad;
  assign push_entry = {Address_I[ZBT_AW-1:0], Data_I};
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  // When the last buffered entry is popped while a new one lands, the new head
  // is not in memory yet, so it is forwarded straight from the input.
  assign next_head = (count > (PW+1)'(1)) ? mem[rd_ptr + PW'(1)] : push_entry;

  assign eth_rise = ETH_active_I & ~eth_prev;
  assign eth_fall = ~ETH_active_I & eth_prev;

  always_comb begin
    done_pending_next = done_pending;
    if (eth_rise)
      done_pending_next = 1'b0;
    else if (eth_fall)
      done_pending_next = 1'b1;
    else if (state == DONE)
      done_pending_next = 1'b0;
  end

  // Ready is registered from the values the FSM and FIFO take at this edge, so
  // it rises together with the return to IDLE.
  always_comb begin
    next_idle = (state == DONE)
              | ((state == IDLE) & (count == '0) & ~done_pending)
              | ((state == WRITE) & pop & (count_next == '0));
    ready_next = next_idle & (count_next == '0) & ~ETH_active_I & ~done_pending_next;
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      eth_prev        <= 1'b0;
      done_pending    <= 1'b0;
      Words_written_O <= '0;
      Overflow_O      <= 1'b0;
      Range_error_O   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count        <= count_next;
      eth_prev     <= ETH_active_I;
      done_pending <= done_pending_next;
      // A load start clears the stats, but events at the same edge still count.
      Words_written_O <= (eth_rise ? 24'd0 : Words_written_O) + 24'(pop);
      Overflow_O      <= (eth_rise ? 1'b0 : Overflow_O) | drop_full;
      Range_error_O   <= (eth_rise ? 1'b0 : Range_error_O) | drop_range;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      ZBT_req_O     <= 1'b0;
      ZBT_address_O <= '0;
      ZBT_data_O    <= '0;
      ZBT_ready_O   <= 1'b0;
      Load_done_O   <= 1'b0;
    end else begin
      Load_done_O <= 1'b0;
      ZBT_ready_O <= ready_next;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state                       <= WRITE;
            ZBT_req_O                   <= 1'b1;
            {ZBT_address_O, ZBT_data_O} <= mem[rd_ptr];
          end else if (done_pending) begin
            state       <= DONE;
            Load_done_O <= 1'b1;
          end
        end
        WRITE: begin
          if (pop) begin
            if (count_next != '0) begin
              {ZBT_address_O, ZBT_data_O} <= next_head;
            end else begin
              state     <= IDLE;
              ZBT_req_O <= 1'b0;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
